// File: rtl/add_sub.sv
// add_sub: registered two's-complement adder/subtractor for the ALU datapath.
// Every cycle both in1+in2 and in1-in2 are formed from the same operands and,
// when valid_in is high, captured together with their signed-overflow flags.
// Downstream logic picks whichever result it needs; there is no mode select.
module add_sub #(
   parameter int LEN = 9
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           valid_in,
   input  logic [LEN-1:0] in1,
   input  logic [LEN-1:0] in2,
   output logic           valid_out,
   output logic [LEN-1:0] outAdd,
   output logic [LEN-1:0] outSub,
   output logic           overflowA,
   output logic           overflowS
);

   // Constant one used as the carry-in of the subtraction (in1 + ~in2 + 1).
   localparam logic [LEN-1:0] ONE = {{(LEN-1){1'b0}}, 1'b1};

   logic [LEN-1:0] sum;
   logic [LEN-1:0] diff;
   logic [LEN-1:0] in2Inv;
   logic           signA;
   logic           signB;
   logic           ovfAdd;
   logic           ovfSub;

   // Combinational arithmetic feeding the result registers. Both results wrap
   // modulo 2^LEN; the most-negative operand is handled naturally by the
   // invert-and-add-one form of subtraction.
   always_comb begin
      in2Inv = ~in2;
      sum    = in1 + in2;
      diff   = in1 + in2Inv + ONE;
      signA  = in1[LEN-1];
      signB  = in2[LEN-1];
      ovfAdd = (signA == signB) && (sum[LEN-1] != signA);
      ovfSub = (signA != signB) && (diff[LEN-1] != signA);
   end

   // Valid tracks valid_in every cycle, so it falls one cycle after valid_in
   // does; reset clears it so an in-flight result is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
      end
   end

   // Results and flags load only on valid operands and otherwise hold, which
   // lets downstream logic sample them at leisure after valid_out drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         outAdd    <= '0;
         outSub    <= '0;
         overflowA <= 1'b0;
         overflowS <= 1'b0;
      end else if (valid_in) begin
         outAdd    <= sum;
         outSub    <= diff;
         overflowA <= ovfAdd;
         overflowS <= ovfSub;
      end
   end

endmodule

// File: tb/tb_add_sub.sv
// tb_add_sub: directed testbench for add_sub with hand-computed expectations.
module tb_add_sub;

   localparam int LEN = 9;

   logic           clk;
   logic           reset;
   logic           valid_in;
   logic [LEN-1:0] in1;
   logic [LEN-1:0] in2;
   logic           valid_out;
   logic [LEN-1:0] outAdd;
   logic [LEN-1:0] outSub;
   logic           overflowA;
   logic           overflowS;

   int errors = 0;
   int checks = 0;

   // Observed output bundle: {valid_out, outAdd, outSub, overflowA, overflowS}
   logic [2*LEN+2:0] obs;
   logic [2*LEN+2:0] exp;

   add_sub #(.LEN(LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .in1       (in1),
      .in2       (in2),
      .valid_out (valid_out),
      .outAdd    (outAdd),
      .outSub    (outSub),
      .overflowA (overflowA),
      .overflowS (overflowS)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {valid_out, outAdd, outSub, overflowA, overflowS};

   // Drive operands on the falling edge (integers truncated to LEN bits), then
   // step past the next rising edge so outputs are sampled away from it.
   task automatic applyStimulus(input int a, input int b, input logic v, input logic r);
      @(negedge clk);
      in1      = a[LEN-1:0];
      in2      = b[LEN-1:0];
      valid_in = v;
      reset    = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      applyStimulus(100, 88, 1'b1, 1'b1);
      applyStimulus(7, 9, 1'b1, 1'b1);
      exp = '0;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL reset_state got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_basic;
      applyStimulus(100, 88, 1'b1, 1'b0);
      exp = {1'b1, 9'd188, 9'd12, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL basic_100_88 got=%h want=%h", obs, exp);
      end
      applyStimulus(3297, 323, 1'b1, 1'b0);
      exp = {1'b1, 9'd36, 9'd414, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL trunc_3297_323 got=%h want=%h", obs, exp);
      end
      applyStimulus(2121, -231, 1'b1, 1'b0);
      exp = {1'b1, 9'd354, 9'd304, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL trunc_2121_m231 got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_overflow;
      applyStimulus(200, 100, 1'b1, 1'b0);
      exp = {1'b1, 9'd300, 9'd100, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL ovf_200_100 got=%h want=%h", obs, exp);
      end
      applyStimulus(-256, -1, 1'b1, 1'b0);
      exp = {1'b1, 9'd255, 9'd257, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL ovf_m256_m1 got=%h want=%h", obs, exp);
      end
      applyStimulus(0, -256, 1'b1, 1'b0);
      exp = {1'b1, 9'd256, 9'd256, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL sub_most_negative got=%h want=%h", obs, exp);
      end
      applyStimulus(255, 1, 1'b1, 1'b0);
      exp = {1'b1, 9'd256, 9'd254, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL ovf_max_plus_one got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_back_to_back;
      applyStimulus(10, 20, 1'b1, 1'b0);
      exp = {1'b1, 9'd30, 9'd502, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL b2b_0 got=%h want=%h", obs, exp);
      end
      applyStimulus(-50, 30, 1'b1, 1'b0);
      exp = {1'b1, 9'd492, 9'd432, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL b2b_1 got=%h want=%h", obs, exp);
      end
      applyStimulus(-200, 100, 1'b1, 1'b0);
      exp = {1'b1, 9'd412, 9'd212, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL b2b_2 got=%h want=%h", obs, exp);
      end
      applyStimulus(1, 2, 1'b0, 1'b0);
      exp = {1'b0, 9'd412, 9'd212, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL hold_0 got=%h want=%h", obs, exp);
      end
      applyStimulus(120, -3, 1'b0, 1'b0);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL hold_1 got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_reset_midstream;
      applyStimulus(40, 2, 1'b1, 1'b0);
      exp = {1'b1, 9'd42, 9'd38, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL pre_reset got=%h want=%h", obs, exp);
      end
      applyStimulus(60, 5, 1'b1, 1'b1);
      exp = '0;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL reset_midstream got=%h want=%h", obs, exp);
      end
      applyStimulus(5, 3, 1'b1, 1'b0);
      exp = {1'b1, 9'd8, 9'd2, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL after_release got=%h want=%h", obs, exp);
      end
      applyStimulus(0, 0, 1'b0, 1'b0);
      exp = {1'b0, 9'd8, 9'd2, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL after_release_hold got=%h want=%h", obs, exp);
      end
   endtask

   // Run every scenario in sequence, then report.
   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      in1      = '0;
      in2      = '0;
      test_reset;
      test_basic;
      test_overflow;
      test_back_to_back;
      test_reset_midstream;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
